// File: rtl/bank_byte_reader.sv
// Load unit front-end: fetches one 32-bit word from a memory bank and returns the
// selected byte/halfword/word, sign- or zero-extended, with error reporting.
module bank_byte_reader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              bank_rd_en,
  output logic [ADDR_W-3:0] bank_addr,
  input  logic              bank_ack,
  input  logic [31:0]       bank_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [7:0] to_last = 8'(TIMEOUT - 1);

  logic [1:0]        state_reg;
  logic [1:0]        lane_reg;
  logic [1:0]        size_reg;
  logic              signed_reg;
  logic [7:0]        cnt_reg;
  logic [31:0]       rsp_data_reg;
  logic              rsp_err_reg;
  logic [ADDR_W-3:0] bank_addr_reg;
  logic              req_bad;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[7:0];
    h = w[15:0];
    r = w;
    case (a)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = {{24{sg & b[7]}}, b};
      2'b01:   r = {{16{sg & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Alignment/size errors are decided at acceptance so the bank is never touched.
  assign req_bad = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      lane_reg      <= 2'b00;
      size_reg      <= 2'b00;
      signed_reg    <= 1'b0;
      cnt_reg       <= 8'd0;
      rsp_data_reg  <= 32'd0;
      rsp_err_reg   <= 1'b0;
      bank_addr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            lane_reg   <= req_addr[1:0];
            size_reg   <= req_size;
            signed_reg <= req_signed;
            cnt_reg    <= 8'd0;
            if (req_bad) begin
              rsp_err_reg  <= 1'b1;
              rsp_data_reg <= 32'd0;
              state_reg    <= RESP;
            end else begin
              bank_addr_reg <= req_addr[ADDR_W-1:2];
              state_reg     <= READ;
            end
          end
        end
        READ: begin
          // An ack on the final allowed cycle still wins over the timeout.
          if (bank_ack) begin
            rsp_data_reg <= extract(bank_rdata, lane_reg, size_reg, signed_reg);
            rsp_err_reg  <= 1'b0;
            state_reg    <= RESP;
          end else if (cnt_reg == to_last) begin
            rsp_data_reg <= 32'd0;
            rsp_err_reg  <= 1'b1;
            state_reg    <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign bank_rd_en = (state_reg == READ);
  assign rsp_valid  = (state_reg == RESP);
  assign bank_addr  = bank_addr_reg;
  assign rsp_data   = rsp_data_reg;
  assign rsp_err    = rsp_err_reg;

endmodule

// File: tb/tb_bank_byte_reader.sv
// Directed bench for bank_byte_reader: vector table for single loads, plus
// timeout, backpressure and mid-read reset sequences.
module tb_bank_byte_reader;

  localparam int AW = 10;
  localparam int TO = 15;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_size;
  logic          req_signed;
  logic          bank_rd_en;
  logic [AW-3:0] bank_addr;
  logic          bank_ack;
  logic [31:0]   bank_rdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic          rsp_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  bank_byte_reader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed),
    .bank_rd_en(bank_rd_en), .bank_addr(bank_addr), .bank_ack(bank_ack),
    .bank_rdata(bank_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    size;
    logic          sgn;
    logic [31:0]   rdata;
    logic [31:0]   exp_data;
    logic          exp_err;
    logic [AW-3:0] exp_bank;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [1:0] s, input logic sg);
    req_addr   = a;
    req_size   = s;
    req_signed = sg;
    req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hs_req_ready", 32'(req_ready), 32'd1);
    chk("hs_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int n;
    vecs[0]  = '{10'h003, 2'b00, 1'b1, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 8'h00};
    vecs[1]  = '{10'h006, 2'b01, 1'b0, 32'hBEEF_0000, 32'h0000_BEEF, 1'b0, 8'h01};
    vecs[2]  = '{10'h006, 2'b01, 1'b1, 32'hBEEF_0000, 32'hFFFF_BEEF, 1'b0, 8'h01};
    vecs[3]  = '{10'h002, 2'b10, 1'b0, 32'h0,         32'h0,         1'b1, 8'h00};
    vecs[4]  = '{10'h001, 2'b11, 1'b0, 32'h0,         32'h0,         1'b1, 8'h00};
    vecs[5]  = '{10'h010, 2'b10, 1'b1, 32'h8765_4321, 32'h8765_4321, 1'b0, 8'h04};
    vecs[6]  = '{10'h00D, 2'b00, 1'b0, 32'h1122_F344, 32'h0000_00F3, 1'b0, 8'h03};
    vecs[7]  = '{10'h00D, 2'b00, 1'b1, 32'h1122_F344, 32'hFFFF_FFF3, 1'b0, 8'h03};
    vecs[8]  = '{10'h00C, 2'b01, 1'b1, 32'h0000_7FFF, 32'h0000_7FFF, 1'b0, 8'h03};
    vecs[9]  = '{10'h005, 2'b01, 1'b1, 32'h0,         32'h0,         1'b1, 8'h00};
    vecs[10] = '{10'h3FE, 2'b00, 1'b1, 32'h007F_0000, 32'h0000_007F, 1'b0, 8'hFF};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = 2'b00; req_signed = 1'b0;
    bank_ack = 1'b0; bank_rdata = 32'd0; rsp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_bank_rd_en", 32'(bank_rd_en), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_bank_addr", 32'(bank_addr), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].addr, vecs[i].size, vecs[i].sgn);
      if (vecs[i].exp_err) begin
        chk($sformatf("v%0d_no_rd", i), 32'(bank_rd_en), 32'd0);
      end else begin
        chk($sformatf("v%0d_rd_en", i), 32'(bank_rd_en), 32'd1);
        chk($sformatf("v%0d_bank_addr", i), 32'(bank_addr), 32'(vecs[i].exp_bank));
        chk($sformatf("v%0d_early_valid", i), 32'(rsp_valid), 32'd0);
        bank_ack = 1'b1; bank_rdata = vecs[i].rdata;
        tick();
        bank_ack = 1'b0; bank_rdata = 32'd0;
      end
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].exp_data);
      chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
      handshake();
    end

    // Timeout: count read-strobe cycles until the error response appears.
    issue(10'h004, 2'b00, 1'b0);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid) break;
      if (bank_rd_en) n++;
      tick();
    end
    chk("to_rd_cycles", 32'(n), 32'(TO));
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rd_en_low", 32'(bank_rd_en), 32'd0);
    bank_ack = 1'b1; bank_rdata = 32'hFFFF_FFFF;
    tick();
    bank_ack = 1'b0; bank_rdata = 32'd0;
    chk("to_late_ack_data", rsp_data, 32'd0);
    chk("to_late_ack_err", 32'(rsp_err), 32'd1);
    chk("to_late_ack_valid", 32'(rsp_valid), 32'd1);
    handshake();

    // Backpressure with an ignored request pending during RESP.
    issue(10'h003, 2'b00, 1'b1);
    bank_ack = 1'b1; bank_rdata = 32'h80FF_1234;
    tick();
    bank_ack = 1'b0; bank_rdata = 32'd0;
    req_addr = 10'h008; req_size = 2'b10; req_signed = 1'b0; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_data", c), rsp_data, 32'hFFFF_FF80);
      chk($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'd0);
      chk($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_ready_after_hs", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("bp_next_rd_en", 32'(bank_rd_en), 32'd1);
    chk("bp_next_bank_addr", 32'(bank_addr), 32'h2);

    // Reset while the read strobe is active.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_rd_en", 32'(bank_rd_en), 32'd0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_rsp_data", rsp_data, 32'd0);
    chk("mr_rsp_err", 32'(rsp_err), 32'd0);
    chk("mr_bank_addr", 32'(bank_addr), 32'd0);
    chk("mr_req_ready", 32'(req_ready), 32'd1);
    tick();
    chk("mr_req_ready2", 32'(req_ready), 32'd1);
    chk("mr_rsp_valid2", 32'(rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
